// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation/bring-up controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller state enum, pass value, default magic addresses.
// The default addresses match the firmware linker map.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HALTED     = 2'd2
    } state_t;

    // A value of 1 written to the exit register means the program passed.
    localparam int PASS_VALUE = 1;

    localparam logic [31:0] DEFAULT_EXIT_ADDR    = 32'h3000_0000;
    localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h1000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with fall-through head (pop_dat shows the oldest entry).
// Latency: a pushed word is visible on pop_dat one cycle after the push edge.
// Backpressure: a push is taken when not full, or when full and popped the same cycle.
// Ports: clk, rst (sync, active high), push/push_dat, pop, pop_dat, full, empty, count.
// The caller detects a dropped push as push & full & ~pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // When full, the slot being freed by a same-cycle pop is the one written.
    assign push_ok = push & (~full | pop_ok);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sim_ctrl.sv
// Bring-up controller: core reset sequencing, exit/console snooping, watchdog.
// Latency: status and console push take effect on the edge after the bus write.
// Backpressure: console bytes arriving at a full FIFO without a pop are dropped (sticky fifo_overflow).
// Ports: clk, rst (sync, active high), core_resetn; bus snoop mem_valid/mem_we/mem_addr/mem_wdata;
//        console char_valid/char_data/char_ready; status done/pass/timeout/exit_code/cycle_count/fifo_overflow.
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 1_000_000,
    parameter logic [ADDR_W-1:0] EXIT_ADDR      = ADDR_W'(DEFAULT_EXIT_ADDR),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(DEFAULT_CONSOLE_ADDR),
    parameter int                FIFO_DEPTH     = 8,
    parameter int                CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_resetn,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              fifo_overflow
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_last;
    logic              exit_wr;
    logic              con_wr;
    logic              tmo_hit;
    logic              in_hold;
    logic              in_run;
    logic              bus_live;
    logic              exit_take;
    logic              tmo_take;
    logic              con_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    unused_fifo_count;

    // Bus decode: full-width address match, writes only, no strobe check.
    assign exit_wr   = mem_valid & mem_we & (mem_addr == EXIT_ADDR);
    assign con_wr    = mem_valid & mem_we & (mem_addr == CONSOLE_ADDR);
    assign hold_last = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdog
            assign tmo_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wdog
            assign tmo_hit = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RESET_HOLD;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RESET_HOLD: if (hold_last)          state_nxt = RUN;
            RUN:        if (exit_wr || tmo_hit) state_nxt = HALTED;
            HALTED:                             state_nxt = HALTED;
            default:                            state_nxt = RESET_HOLD;
        endcase
    end

    // State decode.
    always_comb begin
        in_hold  = 1'b0;
        in_run   = 1'b0;
        bus_live = 1'b0;
        unique case (state)
            RESET_HOLD: in_hold = 1'b1;
            RUN: begin
                in_run   = 1'b1;
                bus_live = 1'b1;
            end
            HALTED:  bus_live = 1'b1;
            default: ;
        endcase
    end

    // Exit beats a same-cycle watchdog expiry.
    assign exit_take = in_run & exit_wr;
    assign tmo_take  = in_run & tmo_hit & ~exit_wr;
    assign con_push  = bus_live & con_wr;
    assign char_valid = ~fifo_empty;
    assign fifo_pop   = char_valid & char_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt      <= '0;
            core_resetn   <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            exit_code     <= '0;
            cycle_count   <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (in_hold) hold_cnt <= hold_cnt + HOLD_W'(1);
            // Registered so the core sees a clean release on the edge entering RUN.
            core_resetn <= (state_nxt != RESET_HOLD);
            if (in_run && (cycle_count != '1)) cycle_count <= cycle_count + CNT_W'(1);
            if (exit_take) begin
                done      <= 1'b1;
                pass      <= (mem_wdata == DATA_W'(PASS_VALUE));
                exit_code <= mem_wdata >> 1;
            end else if (tmo_take) begin
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
            if (con_push && fifo_full && !fifo_pop) fifo_overflow <= 1'b1;
        end
    end

    // Occupancy is not needed here; full/empty cover all decisions.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (con_push),
        .push_dat (mem_wdata[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (char_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (unused_fifo_count)
    );

endmodule
